// File: rtl/lcd_stream_sequencer.sv
// Word source for the 9-bit SPI LCD transmitter: plays the panel init sequence,
// then loops forever programming the address window and streaming RGB565 pixels.
module lcd_stream_sequencer #(
  parameter int unsigned H_RES        = 160,
  parameter int unsigned V_RES        = 128,
  parameter int unsigned ADDR_W       = 15,
  parameter logic [23:0] DELAY_CYCLES = 24'd6_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_idle,
  input  logic [15:0]       pixel_data,
  output logic [8:0]        spi_data,
  output logic              spi_valid,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              init_done,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [7:0]        H_LAST    = 8'(H_RES - 1);
  localparam logic [7:0]        V_LAST    = 8'(V_RES - 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT, DELAY, WIN, FETCH, PIX_HI, PIX_LO} state_t;
  typedef enum logic [1:0] {ISSUE, ACK, DONE} phase_t;

  state_t      state, state_d;
  phase_t      phase, phase_d;
  logic [23:0] cnt, cnt_d;
  logic [3:0]  idx, idx_d;
  logic [15:0] hold, hold_d;
  logic        fetch_wait, fetch_wait_d;
  logic [ADDR_W-1:0] addr_d;
  logic [8:0]  data_d;
  logic        valid_d, init_done_d, frame_done_d;

  logic [8:0]  cur_word;
  logic        cur_delayed;
  logic        sending, word_done, delay_done;

  // Word currently owed to the transmitter, selected by state and table index.
  always_comb begin
    cur_word    = 9'h000;
    cur_delayed = 1'b0;
    case (state)
      INIT: begin
        case (idx)
          4'd0:    begin cur_word = 9'h001; cur_delayed = 1'b1; end
          4'd1:    begin cur_word = 9'h011; cur_delayed = 1'b1; end
          4'd2:    cur_word = 9'h03A;
          4'd3:    cur_word = 9'h105;
          4'd4:    cur_word = 9'h036;
          4'd5:    cur_word = 9'h100;
          default: cur_word = 9'h029;
        endcase
      end
      WIN: begin
        case (idx)
          4'd0:    cur_word = 9'h02A;
          4'd4:    cur_word = {1'b1, H_LAST};
          4'd5:    cur_word = 9'h02B;
          4'd9:    cur_word = {1'b1, V_LAST};
          4'd10:   cur_word = 9'h02C;
          default: cur_word = 9'h100;
        endcase
      end
      PIX_HI:  cur_word = {1'b1, hold[15:8]};
      PIX_LO:  cur_word = {1'b1, hold[7:0]};
      default: cur_word = 9'h000;
    endcase
  end

  assign sending    = (state == INIT) || (state == WIN) || (state == PIX_HI) || (state == PIX_LO);
  assign word_done  = sending && (phase == DONE) && spi_idle;
  assign delay_done = (DELAY_CYCLES == 24'd0) || (cnt == DELAY_CYCLES - 24'd1);

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    cnt_d        = cnt;
    idx_d        = idx;
    hold_d       = hold;
    fetch_wait_d = fetch_wait;
    addr_d       = pixel_addr;
    data_d       = spi_data;
    valid_d      = 1'b0;
    init_done_d  = init_done;
    frame_done_d = 1'b0;

    // Strobe only from ISSUE, so a second word cannot slip out before idle drops.
    if (sending) begin
      case (phase)
        ISSUE: if (spi_idle) begin
          valid_d = 1'b1;
          data_d  = cur_word;
          phase_d = ACK;
        end
        ACK:     if (!spi_idle) phase_d = DONE;
        DONE:    if (spi_idle) phase_d = ISSUE;
        default: phase_d = ISSUE;
      endcase
    end

    case (state)
      PWR_WAIT, DELAY: begin
        if (delay_done) begin
          cnt_d   = '0;
          state_d = INIT;
        end else begin
          cnt_d = cnt + 24'd1;
        end
      end
      INIT: if (word_done) begin
        if (idx == 4'd6) begin
          init_done_d = 1'b1;
          idx_d       = '0;
          state_d     = WIN;
        end else begin
          idx_d   = idx + 4'd1;
          state_d = cur_delayed ? DELAY : INIT;
        end
      end
      WIN: if (word_done) begin
        if (idx == 4'd10) begin
          idx_d        = '0;
          addr_d       = '0;
          fetch_wait_d = 1'b0;
          state_d      = FETCH;
        end else begin
          idx_d = idx + 4'd1;
        end
      end
      FETCH: begin
        // First cycle lets the synchronous RAM register the new address.
        if (!fetch_wait) begin
          fetch_wait_d = 1'b1;
        end else begin
          fetch_wait_d = 1'b0;
          hold_d       = pixel_data;
          state_d      = PIX_HI;
        end
      end
      PIX_HI: if (word_done) state_d = PIX_LO;
      PIX_LO: if (word_done) begin
        if (pixel_addr == LAST_ADDR) begin
          frame_done_d = 1'b1;
          addr_d       = '0;
          state_d      = WIN;
        end else begin
          addr_d  = pixel_addr + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PWR_WAIT;
      phase      <= ISSUE;
      cnt        <= '0;
      idx        <= '0;
      hold       <= '0;
      fetch_wait <= 1'b0;
      pixel_addr <= '0;
      spi_data   <= '0;
      spi_valid  <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      hold       <= hold_d;
      fetch_wait <= fetch_wait_d;
      pixel_addr <= addr_d;
      spi_data   <= data_d;
      spi_valid  <= valid_d;
      init_done  <= init_done_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_lcd_stream_sequencer.sv
// Bench for lcd_stream_sequencer: vector table for init/window/first pixels,
// randomized transmitter timing against a stream reference, and reset corners.
module tb_lcd_stream_sequencer;

  localparam int          H    = 4;
  localparam int          V    = 2;
  localparam int          AW   = 4;
  localparam int          NPIX = H * V;
  localparam logic [23:0] DLY  = 24'd4;
  localparam int          NRAND = 83;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          spi_idle = 1'b1;
  logic [15:0]   pixel_data;
  logic [8:0]    spi_data;
  logic          spi_valid;
  logic [AW-1:0] pixel_addr;
  logic          init_done;
  logic          frame_done;

  logic [15:0] ram [16];
  bit          noise = 1'b1;
  int          total = 0;
  int          bad = 0;
  int          fd_count = 0;

  typedef struct {
    logic [8:0] word;
    bit         init;
    int         addr;
    int         pre;
    int         busy;
    bit         last_init;
  } vec_t;
  vec_t vec[$];

  typedef struct {
    logic [8:0] word;
    int         addr;
    int         frames;
    bit         init;
  } ref_t;
  ref_t rq[$];

  lcd_stream_sequencer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DELAY_CYCLES(DLY)) dut (
    .clk(clk), .rst(rst), .spi_idle(spi_idle), .pixel_data(pixel_data),
    .spi_data(spi_data), .spi_valid(spi_valid), .pixel_addr(pixel_addr),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer RAM; random noise on its output while in reset.
  always @(posedge clk) pixel_data <= noise ? 16'($urandom) : ram[pixel_addr];

  task automatic tick();
    @(posedge clk);
    #1;
    if (frame_done) fd_count++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input int max, output bit ok);
    int n = 0;
    while (!spi_valid && n < max) begin
      tick();
      n++;
    end
    ok = spi_valid;
  endtask

  // Transmitter model: idle stays high for pre cycles, then low for busy cycles.
  task automatic respond(input int pre, input int busy);
    bit extra = 1'b0;
    for (int i = 0; i < pre; i++) begin
      tick();
      if (spi_valid) extra = 1'b1;
    end
    spi_idle = 1'b0;
    for (int i = 0; i < busy; i++) begin
      tick();
      if (spi_valid) extra = 1'b1;
    end
    spi_idle = 1'b1;
    chk("single_strobe_per_word", 32'(extra), 0);
  endtask

  task automatic reset_hold(input int n);
    rst   = 1'b0;
    noise = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_idle = 1'($urandom);
      tick();
      chk("reset_outputs", {spi_data, spi_valid, pixel_addr, init_done, frame_done}, 0);
    end
    noise    = 1'b0;
    spi_idle = 1'b1;
  endtask

  task automatic release_and_latency();
    int first = 0;
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (spi_valid) begin
        first = k;
        break;
      end
    end
    chk("first_valid_latency", first, 32'(DLY) + 1);
    chk("first_word", spi_data, 9'h001);
    chk("init_done_at_start", init_done, 0);
  endtask

  function automatic void add(input logic [8:0] w, input bit in, input int a,
                              input int pre, input int busy, input bit last);
    vec.push_back('{w, in, a, pre, busy, last});
  endfunction

  initial begin
    logic [8:0] init_w [7];
    logic [8:0] win_w [11];
    bit ok;

    init_w = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h036, 9'h100, 9'h029};
    win_w  = '{9'h02A, 9'h100, 9'h100, 9'h100, {1'b1, 8'(H - 1)},
               9'h02B, 9'h100, 9'h100, 9'h100, {1'b1, 8'(V - 1)}, 9'h02C};
    for (int i = 0; i < 16; i++) ram[i] = 16'hA500 + 16'(i);

    // word, init_done, pixel_addr, pre-ack cycles, busy cycles, last init word
    add(9'h001, 0, 0, 0, 18, 0);
    add(9'h011, 0, 0, 0, 18, 0);
    add(9'h03A, 0, 0, 0, 18, 0);
    add(9'h105, 0, 0, 0, 18, 0);
    add(9'h036, 0, 0, 10, 18, 0);
    add(9'h100, 0, 0, 0, 18, 0);
    add(9'h029, 0, 0, 0, 18, 1);
    add(9'h02A, 1, 0, 0, 3, 0);
    add(9'h100, 1, 0, 1, 2, 0);
    add(9'h100, 1, 0, 0, 1, 0);
    add(9'h100, 1, 0, 2, 3, 0);
    add(9'h103, 1, 0, 0, 2, 0);
    add(9'h02B, 1, 0, 0, 3, 0);
    add(9'h100, 1, 0, 1, 1, 0);
    add(9'h100, 1, 0, 0, 2, 0);
    add(9'h100, 1, 0, 0, 3, 0);
    add(9'h101, 1, 0, 3, 1, 0);
    add(9'h02C, 1, 0, 0, 2, 0);
    add(9'h1A5, 1, 0, 0, 2, 0);
    add(9'h100, 1, 0, 1, 2, 0);
    add(9'h1A5, 1, 1, 0, 2, 0);
    add(9'h101, 1, 1, 0, 2, 0);

    reset_hold(6);
    release_and_latency();

    foreach (vec[i]) begin
      wait_strobe(200, ok);
      if (!ok) begin
        chk($sformatf("strobe_timeout_table[%0d]", i), 0, 1);
        break;
      end
      chk($sformatf("table_word[%0d]", i), spi_data, vec[i].word);
      chk($sformatf("table_init_done[%0d]", i), init_done, vec[i].init);
      chk($sformatf("table_addr[%0d]", i), pixel_addr, vec[i].addr);
      respond(vec[i].pre, vec[i].busy);
      if (vec[i].last_init) begin
        chk("init_done_before_029_done", init_done, 0);
        tick();
        chk("init_done_rise", init_done, 1);
      end
    end

    // Randomized transmitter timing over random framebuffer contents.
    reset_hold(4);
    for (int i = 0; i < 16; i++) ram[i] = (i < NPIX) ? 16'($urandom) : 16'hDEAD;
    rq.delete();
    foreach (init_w[i]) rq.push_back('{init_w[i], 0, 0, 1'b0});
    for (int f = 0; rq.size() < NRAND; f++) begin
      foreach (win_w[i]) rq.push_back('{win_w[i], 0, f, 1'b1});
      for (int p = 0; p < NPIX; p++) begin
        rq.push_back('{{1'b1, ram[p][15:8]}, p, f, 1'b1});
        rq.push_back('{{1'b1, ram[p][7:0]}, p, f, 1'b1});
      end
    end
    fd_count = 0;
    release_and_latency();

    for (int k = 0; k < NRAND; k++) begin
      wait_strobe(300, ok);
      if (!ok) begin
        chk($sformatf("strobe_timeout_rand[%0d]", k), 0, 1);
        break;
      end
      chk($sformatf("rand_word[%0d]", k), spi_data, rq[k].word);
      chk($sformatf("rand_addr[%0d]", k), pixel_addr, rq[k].addr);
      chk($sformatf("rand_frame_done_count[%0d]", k), fd_count, rq[k].frames);
      chk($sformatf("rand_init_done[%0d]", k), init_done, rq[k].init);
      if (k < NRAND - 1) respond($urandom_range(3, 0), $urandom_range(6, 1));
    end

    // Last strobe above is the high byte of pixel 5: reset lands mid-word.
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_spi_valid", spi_valid, 0);
    chk("mid_reset_spi_data", spi_data, 0);
    chk("mid_reset_pixel_addr", pixel_addr, 0);
    chk("mid_reset_init_done", init_done, 0);
    chk("mid_reset_frame_done", frame_done, 0);
    reset_hold(3);
    release_and_latency();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
